// File: rtl/rr_onehot_arbiter_4.sv
// 4-way round-robin arbiter with registered one-hot-or-zero grant.
// Define ARB_TIMEOUT_EN to enable the HOLD_MAX grant hold timeout.
module rr_onehot_arbiter_4
`ifdef ARB_TIMEOUT_EN
  #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
  )
`endif
  (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
  );

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] hold;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       pick_vld;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
`else
  assign timeout = 1'b0;
`endif

  // Scan in reverse so the last hit is the first in ptr+1..ptr+4 order.
  always_comb begin
    pick     = ptr;
    cand     = ptr;
    pick_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      ptr       <= 2'd3;
      hold      <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      timeout   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANT;
            hold      <= pick;
            gnt       <= 4'b0001 << pick;
            gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt       <= CNT_W'(1);
`endif
          end
        end
        GRANT: begin
          if (!req[hold]) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= hold;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(HOLD_MAX)) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= hold;
            timeout   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter_4.sv
// Randomized + directed bench for rr_onehot_arbiter_4 against a
// behavioural round-robin model; honours ARB_TIMEOUT_EN.
module tb_rr_onehot_arbiter_4;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  logic [3:0] prev_gnt = 4'b0000;

  rr_onehot_arbiter_4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  // Reference: who owns the grant, who was last served, how long held.
  task automatic model(input logic [3:0] r, input logic rs);
    if (rs) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_cnt   = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_to = 1'b0;
    end else if (EN && m_cnt == HOLD) begin
      m_last = m_owner; m_owner = -1; m_to = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic rs);
    logic [3:0] g;
    @(negedge clk);
    req = r;
    rst = rs;
    model(r, rs);
    @(posedge clk);
    #1;
    g = gnt;
    chk("gnt", 32'(g), 32'(m_gnt()));
    chk("gnt_valid", 32'(gnt_valid), 32'(|m_gnt()));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(g)), 32'd1);
    chk("valid_or", 32'(gnt_valid), 32'(|g));
    chk("no_direct_switch",
        32'(prev_gnt != 4'b0000 && g != 4'b0000 && g != prev_gnt),
        32'd0);
    prev_gnt = g;
  endtask

  initial begin
    // T1: reset then single requester grant and release
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    cyc(4'b0001, 1'b0);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_valid", 32'(gnt_valid), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("t1_rel", 32'(gnt), 32'h0);
    chk("t1_to", 32'(timeout), 32'h0);

    // T3: release of requester 2 then 0101 picks requester 0
    cyc(4'b0000, 1'b1);
    cyc(4'b0100, 1'b0);
    chk("t3_g2", 32'(gnt), 32'h4);
    cyc(4'b0000, 1'b0);
    cyc(4'b0101, 1'b0);
    chk("t3_g0", 32'(gnt), 32'h1);
    cyc(4'b0000, 1'b0);

    // T4: reset mid-grant restores ptr=3
    cyc(4'b0010, 1'b0);
    chk("t4_g1", 32'(gnt), 32'h2);
    cyc(4'b0010, 1'b1);
    chk("t4_gnt", 32'(gnt), 32'h0);
    chk("t4_valid", 32'(gnt_valid), 32'h0);
    chk("t4_to", 32'(timeout), 32'h0);
    cyc(4'b1001, 1'b0);
    chk("t4_g0", 32'(gnt), 32'h1);
    cyc(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // T2: all requesting, HOLD cycles each, one idle timeout cycle
    cyc(4'b0000, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < HOLD; c++) begin
        cyc(4'b1111, 1'b0);
        chk("t2_hold", 32'(gnt), 32'(1 << (r % 4)));
      end
      if (r < 4) begin
        cyc(4'b1111, 1'b0);
        chk("t2_gap", 32'(gnt), 32'h0);
        chk("t2_to", 32'(timeout), 32'h1);
      end
    end
`else
    // T5: held request is never released
    cyc(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0010, 1'b0);
      chk("t5_hold", 32'(gnt), 32'h2);
      chk("t5_to", 32'(timeout), 32'h0);
    end
`endif

    // Random traffic with sticky requesters and rare resets
    cyc(4'b0000, 1'b1);
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 600; i++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
        cyc(r, ($urandom_range(0, 60) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
